// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector bench.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1011;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, shift-left register; ser_out is the MSB.
module seq_piso #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] par_in,
    output logic             ser_out
);

    logic [PAT_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= par_in;
        end else if (shift) begin
            sr <= {sr[PAT_W-2:0], 1'b0};
        end
    end

    assign ser_out = sr[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: repeats a PAT_W-bit pattern MSB-first with an
// optional idle gap between repetitions. All outputs are registered.
module seq_gen
    import seq_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT),
    parameter int               REP_W       = 4,
    parameter int               GAP_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W   = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(PAT_W - 1);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [REP_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_cfg;
    logic [GAP_W-1:0] gap_cnt;
    logic [BIT_W-1:0] bit_cnt;

    logic [PAT_W-1:0] sel_pat;
    logic             accept;
    logic             last_bit;
    logic             more_reps;
    logic             gap_end;
    logic             piso_load;
    logic             piso_shift;
    logic [PAT_W-1:0] piso_din;
    logic             piso_bit;

    // seq_out is registered, so the PISO holds the bits still to come after
    // the one currently on the output; every (re)load skips the MSB.
    always_comb begin
        sel_pat    = use_default ? DEFAULT_PAT : pattern;
        accept     = (state == IDLE) && start && !abort;
        last_bit   = (bit_cnt == '0);
        more_reps  = (rep_q > REP_W'(1));
        gap_end    = (gap_cnt == GAP_W'(1));
        piso_din   = ((state == IDLE) ? sel_pat : pat_q) << 1;
        piso_load  = !reset && (accept
                     || ((state == SEND) && !abort && last_bit && more_reps && (gap_cfg == '0))
                     || ((state == GAP) && !abort && gap_end));
        piso_shift = !reset && (state == SEND) && !abort && !last_bit;
    end

    seq_piso #(.PAT_W(PAT_W)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load    (piso_load),
        .shift   (piso_shift),
        .par_in  (piso_din),
        .ser_out (piso_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_cfg   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    seq_out   <= 1'b0;
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (accept) begin
                        pat_q     <= sel_pat;
                        rep_q     <= (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
                        gap_cfg   <= gap_len;
                        bit_cnt   <= BIT_MSB;
                        seq_out   <= sel_pat[PAT_W-1];
                        seq_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        seq_out   <= 1'b0;
                        seq_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (!last_bit) begin
                        bit_cnt <= bit_cnt - BIT_W'(1);
                        seq_out <= piso_bit;
                    end else if (more_reps) begin
                        rep_q <= rep_q - REP_W'(1);
                        if (gap_cfg == '0) begin
                            bit_cnt <= BIT_MSB;
                            seq_out <= pat_q[PAT_W-1];
                        end else begin
                            gap_cnt   <= gap_cfg;
                            seq_out   <= 1'b0;
                            seq_valid <= 1'b0;
                            state     <= GAP;
                        end
                    end else begin
                        seq_out   <= 1'b0;
                        seq_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                GAP: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else if (gap_end) begin
                        gap_cnt   <= '0;
                        bit_cnt   <= BIT_MSB;
                        seq_out   <= pat_q[PAT_W-1];
                        seq_valid <= 1'b1;
                        state     <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    seq_out   <= 1'b0;
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    seq_out   <= 1'b0;
                    seq_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a transaction-level model queues the expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       use_default = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] repeat_cnt = '0;
    logic [3:0] gap_len = '0;
    logic       abort = 1'b0;
    logic       seq_out, seq_valid, busy, done;

    seq_gen #(.PAT_W(4), .REP_W(4), .GAP_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .use_default (use_default),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap_len     (gap_len),
        .abort       (abort),
        .seq_out     (seq_out),
        .seq_valid   (seq_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expected {seq_out, seq_valid, busy, done} for each non-idle cycle
    logic [3:0] exp_q[$];
    int cyc = 0;
    int idle_from = 0;

    int busy_cnt = 0;
    int det_hits = 0;
    int det_bits = 0;
    logic [3:0] det_sh = '0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] act;
        logic [3:0] req;
        act = {seq_out, seq_valid, busy, done};
        if (busy) busy_cnt++;
        if (seq_valid) begin
            det_sh = {det_sh[2:0], seq_out};
            det_bits++;
            if (det_bits >= 4 && det_sh == 4'b1011) det_hits++;
        end
        if (act != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %b expected idle (t=%0t)", act, $time);
            end else begin
                req = exp_q.pop_front();
                if (act != req) begin
                    errors++;
                    $display("FAIL cycle_outputs: got %b expected %b (t=%0t)", act, req, $time);
                end
            end
        end
    end

    // Behavioural model, evaluated on the inputs sampled at this edge.
    task automatic model_edge();
        logic [3:0] p;
        int n, g;
        if (reset) begin
            exp_q.delete();
            idle_from = cyc + 1;
        end else if (cyc < idle_from) begin
            if (abort && cyc + 1 < idle_from) begin
                exp_q.delete();
                idle_from = cyc + 1;
            end
        end else if (start && !abort) begin
            p = use_default ? 4'b1011 : pattern;
            n = (repeat_cnt == 0) ? 1 : int'(repeat_cnt);
            g = int'(gap_len);
            for (int r = 0; r < n; r++) begin
                for (int b = 3; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
                if (r < n - 1) for (int i = 0; i < g; i++) exp_q.push_back(4'b0010);
            end
            exp_q.push_back(4'b0001);
            idle_from = cyc + n * 4 + (n - 1) * g + 2;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && cyc < idle_from; i++) tick();
        chk("drain_done", int'(cyc >= idle_from), 1);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic go(input logic dflt, input logic [3:0] pat,
                      input logic [3:0] rep, input logic [3:0] gap);
        use_default = dflt; pattern = pat; repeat_cnt = rep; gap_len = gap;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_outputs", int'({seq_out, seq_valid, busy, done}), 0);
        tick();

        // defaults drive one 1011 detection
        det_hits = 0; det_bits = 0; busy_cnt = 0;
        go(1'b1, 4'b0000, 4'd1, 4'd0);
        chk("t1_first_bit", int'({seq_out, seq_valid, busy}), 3'b111);
        wait_idle();
        chk("t1_detections", det_hits, 1);
        chk("t1_busy_cycles", busy_cnt, 4);

        // back-to-back repetitions
        busy_cnt = 0;
        go(1'b0, 4'b1011, 4'd2, 4'd0);
        wait_idle();
        chk("t2_busy_cycles", busy_cnt, 8);

        // gap and zero repeat count
        busy_cnt = 0;
        go(1'b0, 4'b1101, 4'd3, 4'd2);
        wait_idle();
        chk("t3_busy_cycles", busy_cnt, 16);
        busy_cnt = 0;
        go(1'b0, 4'b1001, 4'd0, 4'd3);
        wait_idle();
        chk("t3_rep0_busy", busy_cnt, 4);

        // abort during the second bit, then a late start during SEND
        go(1'b0, 4'b1101, 4'd2, 4'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_outputs", int'({seq_out, seq_valid, busy, done}), 0);
        tick();
        chk("t4_abort_no_done", int'(done), 0);
        busy_cnt = 0;
        go(1'b0, 4'b1010, 4'd2, 4'd0);
        tick();
        use_default = 1'b1; repeat_cnt = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        chk("t4_late_start_busy", busy_cnt, 8);

        // reset mid-gap, then a clean restart
        go(1'b0, 4'b0111, 4'd2, 4'd3);
        repeat (5) tick();
        chk("t5_in_gap", int'({seq_valid, busy}), 2'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_reset_outputs", int'({seq_out, seq_valid, busy, done}), 0);
        go(1'b0, 4'b1100, 4'd1, 4'd0);
        chk("t5_restart_msb", int'({seq_out, seq_valid}), 2'b11);
        wait_idle();

        // pattern change mid-send has no effect
        go(1'b0, 4'b0110, 4'd1, 4'd0);
        pattern = 4'b1111;
        wait_idle();

        // randomized traffic, including mid-stream starts, aborts and resets
        for (int i = 0; i < 4000; i++) begin
            use_default = 1'($urandom);
            pattern     = 4'($urandom);
            repeat_cnt  = 4'($urandom_range(0, 3));
            gap_len     = 4'($urandom_range(0, 3));
            start       = ($urandom % 3) == 0;
            abort       = ($urandom % 60) == 0;
            reset       = ($urandom % 500) == 0;
            tick();
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        wait_idle();
        tick();
        chk("final_idle", int'({seq_out, seq_valid, busy, done}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
